cube_root: RTL

- Iterative unsigned integer cube root: root = floor(cbrt(num)), remainder = num - root^3.
- Inverse companion to the team's pipelined cube unit; sits on the same datapath and lets software and benches round-trip values.
- Computes 3 radicand bits per cycle (shift/subtract, digit-by-digit), so it needs no full-width multiplier.
- Valid/ready on both input and output; one operation in flight at a time.

---
 rtl/cube_root_pkg.sv | 13 +
 rtl/cube_root_iter_step.sv | 35 +++
 rtl/cube_root.sv | 92 +++++++++
 3 files changed

// File: rtl/cube_root_pkg.sv
// Shared types and helpers for the iterative cube-root unit.
package cube_root_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} cbrt_state_t;

    // Radicand bits consumed per iteration.
    localparam int CBRT_SHIFT = 3;

    function automatic int cbrt_iter(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cube_root_iter_step.sv
// One digit-by-digit cube-root step: tries to append a 1 to the partial root.
module cbrt_iter_step #(
    parameter int WIDTH = 32,
    parameter int ITER  = 11,
    parameter int SW    = 6
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [ITER-1:0]  y,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] rem_next,
    output logic [ITER-1:0]  y_next
);
    localparam int TW = 2 * ITER + 2;
    localparam int CW = (WIDTH > TW) ? WIDTH : TW;

    logic [TW-1:0] y2;
    logic [TW-1:0] t;
    logic [CW-1:0] rem_sh;
    logic [CW-1:0] t_cmp;
    logic [CW-1:0] t_sh;
    logic          ge;

    // t = (2y+1)^3 - (2y)^3; compared against rem>>s so the shifted t never overflows.
    always_comb begin
        y2       = {{(TW - ITER - 1){1'b0}}, y, 1'b0};
        t        = TW'(3) * y2 * (y2 + TW'(1)) + TW'(1);
        rem_sh   = CW'(rem >> s);
        t_cmp    = CW'(t);
        ge       = rem_sh >= t_cmp;
        t_sh     = t_cmp << s;
        rem_next = ge ? rem - t_sh[WIDTH-1:0] : rem;
        y_next   = {y[ITER-2:0], ge};
    end

endmodule

// File: rtl/cube_root.sv
// Iterative unsigned cube root, 3 radicand bits per cycle, valid/ready handshake.
// Define CBRT_REMAINDER_EN to expose the remainder port.
module cube_root
    import cube_root_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int ITER  = cbrt_iter(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ITER-1:0]  root
`ifdef CBRT_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);
    localparam int            SW     = $clog2(CBRT_SHIFT * ITER);
    localparam logic [SW-1:0] S_INIT = SW'(CBRT_SHIFT * (ITER - 1));

    cbrt_state_t      state;
    logic [WIDTH-1:0] rem_acc;
    logic [ITER-1:0]  y_acc;
    logic [SW-1:0]    s_cnt;
    logic [WIDTH-1:0] rem_next;
    logic [ITER-1:0]  y_next;

    cbrt_iter_step #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .SW    (SW)
    ) u_step (
        .rem      (rem_acc),
        .y        (y_acc),
        .s        (s_cnt),
        .rem_next (rem_next),
        .y_next   (y_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            root      <= '0;
            rem_acc   <= '0;
            y_acc     <= '0;
            s_cnt     <= '0;
`ifdef CBRT_REMAINDER_EN
            remainder <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem_acc  <= num;
                        y_acc    <= '0;
                        s_cnt    <= S_INIT;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    rem_acc <= rem_next;
                    y_acc   <= y_next;
                    if (s_cnt == '0) state <= DONE;
                    else             s_cnt <= s_cnt - SW'(CBRT_SHIFT);
                end
                // First DONE cycle publishes the result; the handshake needs out_valid already high.
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        root      <= y_acc;
`ifdef CBRT_REMAINDER_EN
                        remainder <= rem_acc;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
